eth_rx_dma_arbiter: RTL and testbench
=====================================

// Module: eth_rx_dma_arbiter
// PURPOSE
//  Packet-level round-robin arbiter that shares the single AXI-Stream DMA S2MM channel
//  among NUM_PORTS Ethernet MAC RX streams. It sits in the PL between the per-port MAC
//  RX FIFOs and the DMA engine in the PS-attached block design. A grant is held for a
//  whole packet (through tlast). The source port index travels on m_axis_tdest.
// PARAMETERS
//  NUM_PORTS  4   number of requesting RX streams (2..8)
//  DATA_W     32  tdata width in bits; tkeep is DATA_W/8 bits
//  IDX_W      2   width of port index = clog2(NUM_PORTS)
// PORTS
//  axis_aclk      in   1                 single clock for all ports
//  axis_aresetn   in   1                 asynchronous reset, active low
//  s_axis_tdata   in   NUM_PORTS*DATA_W  port i data in slice [i*DATA_W +: DATA_W]
//  s_axis_tkeep   in   NUM_PORTS*DATA_W/8  byte enables, same slicing
//  s_axis_tvalid  in   NUM_PORTS         per-port valid
//  s_axis_tlast   in   NUM_PORTS         per-port end of packet
//  s_axis_tready  out  NUM_PORTS         per-port ready
//  m_axis_tdata   out  DATA_W            to DMA S2MM
//  m_axis_tkeep   out  DATA_W/8          to DMA S2MM
//  m_axis_tvalid  out  1                 to DMA S2MM
//  m_axis_tlast   out  1                 to DMA S2MM
//  m_axis_tdest   out  IDX_W             index of the granted source port
//  m_axis_tready  in   1                 from DMA S2MM
//  grant_active   out  1                 high while a packet is in flight (XFER)
// BEHAVIOUR
//  - Reset (axis_aresetn=0, async):
//    - state=IDLE, last_grant=NUM_PORTS-1, so port 0 has first priority.
//    - All outputs 0: s_axis_tready, m_axis_tvalid, grant_active, m_axis_tdest.
//  - FSM IDLE:
//    - If any s_axis_tvalid is high, pick the first requesting port scanning
//      last_grant+1, last_grant+2, ... modulo NUM_PORTS.
//    - Register that port as grant and go to XFER. This costs 1 bubble cycle per packet.
//    - All s_axis_tready are 0 in IDLE.
//  - FSM XFER: combinational pass-through of the granted port.
//    - m_axis_{tdata,tkeep,tvalid,tlast} = s_axis_*[grant].
//    - s_axis_tready[grant] = m_axis_tready; all other tready bits = 0.
//    - m_axis_tdest = grant. grant_active = 1.
//  - Packet end: a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast sets
//    last_grant<=grant and returns to IDLE on the next edge.
//  - Granted source drops tvalid mid-packet: the grant is held indefinitely with no
//    timeout. The next beat continues the same packet.
//  - Single-beat packet (tlast on the first beat) is legal: XFER lasts 1 cycle.
//  - A request appearing on another port during XFER waits. It is not dropped and its
//    tready stays 0.
//  - Only one port requesting: it is re-granted every packet, with a 1-cycle gap.
//  - Fairness: with all ports requesting continuously, grants go 0,1,2,3,0,...
//    No port waits longer than NUM_PORTS-1 packets.
//  - Reset asserted mid-packet: the FSM aborts immediately to IDLE.
//    - The partial packet is not terminated; the DMA side is reset by the same reset.
// CONFIGURATION
//  ARB_STATS_EN defined:
//    - Adds output pkt_cnt [NUM_PORTS*32], where slice i is the count of packets
//      forwarded from port i.
//    - A count increments on the tlast handshake, saturates at 32'hFFFF_FFFF and
//      resets to 0.
//    - Adds input stats_clr (1 bit). It synchronously zeroes all counters.
//    - If a clear and an increment occur in the same cycle, the counter becomes 0.
//  ARB_STATS_EN undefined:
//    - No counters and no pkt_cnt/stats_clr ports. Arbitration is identical.
// TESTING
//  1. Reset, then port 2 sends a 3-beat packet with tdata 0xA0,0xA1,0xA2 and
//     m_axis_tready=1.
//     -> Grant is taken one cycle after tvalid. m_axis shows the 3 beats, tdest=2,
//        and tlast on beat 3.
//  2. All 4 ports each hold a 2-beat packet continuously.
//     -> Packets emerge in tdest order 0,1,2,3,0. There is 1 idle cycle between packets.
//  3. Port 1 mid-packet with m_axis_tready toggling 1,0,1,0.
//     -> Beats advance only on tready=1. s_axis_tready[1] mirrors m_axis_tready, and
//        other tready bits stay 0.
//  4. Port 0 drops tvalid for 5 cycles mid-packet while port 3 requests.
//     -> The grant stays on 0, and port 3 is served only after port 0's tlast.
//  5. Reset pulsed during beat 2 of a 4-beat packet.
//     -> All outputs go 0 at once. After release, port 0 has priority again.
//  6. (ARB_STATS_EN) Send 3 packets on port 1, then pulse stats_clr.
//     -> pkt_cnt[63:32]=3, then 0. Other slices stay 0.

Source files
------------

// File: rtl/eth_rx_dma_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream DMA S2MM channel
// among NUM_PORTS MAC RX streams. Optional packet counters: ARB_STATS_EN.
module eth_rx_dma_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 2
) (
    input  logic                              axis_aclk,
    input  logic                              axis_aresetn,
    input  logic [NUM_PORTS*DATA_W-1:0]       s_axis_tdata,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0]   s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]              s_axis_tlast,
    output logic [NUM_PORTS-1:0]              s_axis_tready,
    output logic [DATA_W-1:0]                 m_axis_tdata,
    output logic [DATA_W/8-1:0]               m_axis_tkeep,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    output logic [IDX_W-1:0]                  m_axis_tdest,
    input  logic                              m_axis_tready,
    output logic                              grant_active
`ifdef ARB_STATS_EN
    ,
    input  logic                              stats_clr,
    output logic [NUM_PORTS*32-1:0]           pkt_cnt
`endif
);

    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;
    logic              sel_valid;
    logic              sel_last;
    logic              pkt_done;

    // Round-robin search: first requester after the last granted port.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_l;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        idx_l      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx   = (int'(last_q) + k) % NUM_PORTS;
            idx_l = IDX_W'(idx);
            if (!pick_found && s_axis_tvalid[idx_l]) begin
                pick_found = 1'b1;
                pick_idx   = idx_l;
            end
        end
    end

    // Select the granted port's stream signals.
    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_data  = s_axis_tdata[i*DATA_W +: DATA_W];
                sel_keep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
            end
        end
    end

    // Next-state and pass-through outputs; grant held until tlast handshake.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdest  = '0;
        grant_active  = 1'b0;
        pkt_done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                grant_active  = 1'b1;
                m_axis_tdest  = grant_q;
                m_axis_tdata  = sel_data;
                m_axis_tkeep  = sel_keep;
                m_axis_tvalid = sel_valid;
                m_axis_tlast  = sel_last;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    s_axis_tready[i] = (grant_q == IDX_W'(i)) & m_axis_tready;
                end
                pkt_done = sel_valid & m_axis_tready & sel_last;
                if (pkt_done) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] cnt_q [NUM_PORTS];

    // Per-port saturating packet counters; clear wins over increment.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
        end else if (stats_clr) begin
            for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
        end else if (pkt_done) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant_q == IDX_W'(i) && cnt_q[i] != 32'hFFFF_FFFF) begin
                    cnt_q[i] <= cnt_q[i] + 32'd1;
                end
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        pkt_cnt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pkt_cnt[i*32 +: 32] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_dma_arbiter.sv
// Scoreboard bench for eth_rx_dma_arbiter: per-port expected beat queues
// and a packet-level round-robin model checked by an independent monitor.
module tb_eth_rx_dma_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int KW = 4;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          gap;
    } beat_t;

    logic            clk;
    logic            rst_n;
    logic [NP*DW-1:0] s_tdata;
    logic [NP*KW-1:0] s_tkeep;
    logic [NP-1:0]   s_tvalid;
    logic [NP-1:0]   s_tlast;
    logic [NP-1:0]   s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid;
    logic            m_tlast;
    logic [1:0]      m_tdest;
    logic            m_tready;
    logic            grant_active;
`ifdef ARB_STATS_EN
    logic            stats_clr;
    logic [NP*32-1:0] pkt_cnt;
`endif

    eth_rx_dma_arbiter #(
        .NUM_PORTS(NP),
        .DATA_W   (DW),
        .IDX_W    (2)
    ) dut (
        .axis_aclk    (clk),
        .axis_aresetn (rst_n),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast (m_tlast),
        .m_axis_tdest (m_tdest),
        .m_axis_tready(m_tready),
        .grant_active (grant_active)
`ifdef ARB_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .pkt_cnt      (pkt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t     pq [NP][$];
    beat_t     ex [NP][$];
    int        log_q [$];
    int        errors = 0;
    int        checks = 0;
    logic [NP-1:0] acc;
    int        tr_mode;
    logic      tr_tog;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(int last, logic [NP-1:0] req);
        for (int k = 1; k <= NP; k++) begin
            if (req[(last + k) % NP]) return (last + k) % NP;
        end
        return 0;
    endfunction

    function automatic logic pending();
        for (int p = 0; p < NP; p++) begin
            if (pq[p].size() != 0 || ex[p].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic add_pkt(int p, int n, int g0, int gpos, int glen,
                           logic [31:0] base, logic rnd);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = rnd ? $urandom : base + 32'(i);
            b.keep = rnd ? 4'($urandom_range(1, 15)) : 4'hF;
            b.last = (i == n - 1);
            b.gap  = (i == 0 ? g0 : 0) + (i == gpos ? glen : 0);
            pq[p].push_back(b);
            ex[p].push_back(b);
        end
    endtask

    task automatic step();
        beat_t b;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            if (acc[p] && pq[p].size() != 0) void'(pq[p].pop_front());
            s_tvalid[p]          = 1'b0;
            s_tlast[p]           = 1'b0;
            s_tdata[p*DW +: DW]  = $urandom;
            s_tkeep[p*KW +: KW]  = 4'($urandom);
            if (pq[p].size() != 0) begin
                b = pq[p][0];
                if (b.gap > 0) begin
                    b.gap--;
                    pq[p][0] = b;
                end else begin
                    s_tvalid[p]         = 1'b1;
                    s_tlast[p]          = b.last;
                    s_tdata[p*DW +: DW] = b.data;
                    s_tkeep[p*KW +: KW] = b.keep;
                end
            end
        end
        case (tr_mode)
            0:       m_tready = 1'b1;
            1:       begin tr_tog = ~tr_tog; m_tready = tr_tog; end
            default: m_tready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        acc = s_tvalid & s_tready;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_s_tready", 64'(s_tready), 64'h0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'h0);
        chk("rst_grant_active", 64'(grant_active), 64'h0);
        chk("rst_tdest", 64'(m_tdest), 64'h0);
        for (int p = 0; p < NP; p++) begin
            pq[p].delete();
            ex[p].delete();
        end
        s_tvalid = '0;
        s_tlast  = '0;
        acc      = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        chk("drain_done", 64'(pending()), 64'h0);
        step();
        step();
    endtask

    task automatic chk_order(string name, int exp_o [$]);
        chk({name, "_len"}, 64'(log_q.size()), 64'(exp_o.size()));
        for (int i = 0; i < exp_o.size() && i < log_q.size(); i++) begin
            chk(name, 64'(log_q[i]), 64'(exp_o[i]));
        end
    endtask

    // Monitor: packet-level arbitration model plus per-port beat scoreboard.
    initial begin : monitor
        logic busy;
        int   last;
        int   cur;
        beat_t e;
        busy = 1'b0;
        last = NP - 1;
        cur  = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                busy = 1'b0;
                last = NP - 1;
                continue;
            end
            chk("grant_active", 64'(grant_active), 64'(busy));
            if (busy) begin
                chk("tdest", 64'(m_tdest), 64'(cur));
                chk("s_tready", 64'(s_tready),
                    m_tready ? 64'(1) << cur : 64'h0);
                chk("m_tvalid", 64'(m_tvalid), 64'(s_tvalid[cur]));
                if (m_tvalid && m_tready) begin
                    if (ex[cur].size() == 0) begin
                        chk("unexpected_beat", 64'h1, 64'h0);
                    end else begin
                        e = ex[cur].pop_front();
                        chk("tdata", 64'(m_tdata), 64'(e.data));
                        chk("tkeep", 64'(m_tkeep), 64'(e.keep));
                        chk("tlast", 64'(m_tlast), 64'(e.last));
                        if (e.last) begin
                            busy = 1'b0;
                            last = cur;
                        end
                    end
                end
            end else begin
                chk("idle_s_tready", 64'(s_tready), 64'h0);
                chk("idle_m_tvalid", 64'(m_tvalid), 64'h0);
                if (|s_tvalid) begin
                    cur  = rr_pick(last, s_tvalid);
                    busy = 1'b1;
                    log_q.push_back(cur);
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        acc      = '0;
        tr_mode  = 0;
        tr_tog   = 1'b0;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("reset_s_tready", 64'(s_tready), 64'h0);
        chk("reset_m_tvalid", 64'(m_tvalid), 64'h0);
        chk("reset_grant", 64'(grant_active), 64'h0);
        chk("reset_tdest", 64'(m_tdest), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3-beat packet on port 2
        log_q.delete();
        add_pkt(2, 3, 0, 0, 0, 32'hA0, 1'b0);
        drain(50);
        chk_order("t1_order", '{2});

        // all ports requesting from a fresh reset
        step();
        do_reset();
        log_q.delete();
        add_pkt(0, 2, 0, 0, 0, 32'h0010, 1'b0);
        add_pkt(1, 2, 0, 0, 0, 32'h0110, 1'b0);
        add_pkt(2, 2, 0, 0, 0, 32'h0210, 1'b0);
        add_pkt(3, 2, 0, 0, 0, 32'h0310, 1'b0);
        add_pkt(0, 2, 0, 0, 0, 32'h0020, 1'b0);
        drain(100);
        chk_order("t2_order", '{0, 1, 2, 3, 0});

        // backpressure toggling on port 1
        tr_mode = 1;
        add_pkt(1, 4, 0, 0, 0, 32'h1000, 1'b0);
        drain(100);
        tr_mode = 0;

        // port 0 stalls mid-packet while port 3 requests
        log_q.delete();
        add_pkt(0, 4, 0, 1, 5, 32'h2000, 1'b0);
        add_pkt(3, 2, 2, 0, 0, 32'h3000, 1'b0);
        drain(100);
        chk_order("t4_order", '{0, 3});

        // reset during beat 2 of a 4-beat packet
        add_pkt(3, 1, 0, 0, 0, 32'h4100, 1'b0);
        drain(50);
        add_pkt(0, 4, 0, 0, 0, 32'h4000, 1'b0);
        n = 0;
        while (ex[0].size() > 3 && n < 20) begin
            step();
            n++;
        end
        chk("t5_beat1_seen", 64'(ex[0].size()), 64'd3);
        step();
        do_reset();
        log_q.delete();
        add_pkt(3, 2, 0, 0, 0, 32'h5300, 1'b0);
        add_pkt(2, 2, 0, 0, 0, 32'h5200, 1'b0);
        add_pkt(0, 2, 0, 0, 0, 32'h5000, 1'b0);
        drain(100);
        chk_order("t5_order", '{0, 2, 3});

        // randomized traffic with stalls and backpressure
        tr_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                n = $urandom_range(0, NP - 1);
                if (pq[n].size() < 8) begin
                    add_pkt(n, $urandom_range(1, 5), $urandom_range(0, 3),
                            $urandom_range(1, 4), $urandom_range(0, 3),
                            32'h0, 1'b1);
                end
            end
            step();
        end
        drain(3000);
        tr_mode = 0;

`ifdef ARB_STATS_EN
        // packet counters
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        for (int i = 0; i < 3; i++) add_pkt(1, 2, 0, 0, 0, 32'h6000, 1'b0);
        drain(100);
        chk("cnt_p0", 64'(pkt_cnt[31:0]), 64'd0);
        chk("cnt_p1", 64'(pkt_cnt[63:32]), 64'd3);
        chk("cnt_p2", 64'(pkt_cnt[95:64]), 64'd0);
        chk("cnt_p3", 64'(pkt_cnt[127:96]), 64'd0);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        step();
        chk("cnt_clr", 64'(pkt_cnt[63:32]), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
